// File: rtl/s3_pack_pkg.sv
// Shared encodings, FSM states and sizing helper for the S3 radix-3 pack/unpack codec.
package s3_pack_pkg;

    localparam logic [1:0] TRIT_ZERO = 2'b00;
    localparam logic [1:0] TRIT_ONE  = 2'b01;
    localparam logic [1:0] TRIT_TWO  = 2'b10;
    localparam logic [1:0] TRIT_INV  = 2'b11;

    localparam logic MODE_PACK   = 1'b0;
    localparam logic MODE_UNPACK = 1'b1;

    // Largest byte a valid five-trit group can produce (3^5 - 1).
    localparam logic [7:0] BYTE_MAX = 8'd242;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int ngroups(input int n);
        return (n + 4) / 5;
    endfunction

endpackage

// File: rtl/s3_group_conv.sv
// Combinational five-trit <-> one-byte radix-3 converter, both directions at once.
module s3_group_conv
    import s3_pack_pkg::*;
(
    input  logic [9:0] trits_i,
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o,
    output logic [9:0] trits_o,
    output logic       pack_inv_o,
    output logic       unpack_inv_o
);

    // Pack: Horner evaluation from the most significant trit; invalid trits count as zero.
    always_comb begin
        logic [7:0] acc;
        logic [1:0] t;
        acc        = 8'd0;
        t          = TRIT_ZERO;
        pack_inv_o = 1'b0;
        for (int j = 4; j >= 0; j--) begin
            t = trits_i[2*j +: 2];
            if (t == TRIT_INV) begin
                pack_inv_o = 1'b1;
                t          = TRIT_ZERO;
            end else begin
                t = t;
            end
            acc = acc * 8'd3 + {6'd0, t};
        end
        byte_o = acc;
    end

    // Unpack: fold out-of-range bytes back by 243, then peel digits LSB-first.
    always_comb begin
        logic [7:0] rem;
        trits_o = 10'd0;
        if (byte_i > BYTE_MAX) begin
            unpack_inv_o = 1'b1;
            rem          = byte_i - 8'd243;
        end else begin
            unpack_inv_o = 1'b0;
            rem          = byte_i;
        end
        for (int j = 0; j < 5; j++) begin
            trits_o[2*j +: 2] = 2'(rem % 8'd3);
            rem               = rem / 8'd3;
        end
    end

endmodule

// File: rtl/s3_pack_codec.sv
// Sequential S3 polynomial <-> packed-byte codec: one five-trit group per cycle,
// start/busy/done handshake and a sticky invalid-input flag.
module s3_pack_codec
    import s3_pack_pkg::*;
#(
    parameter int N_COEF = 700
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       mode,
    input  logic [2*N_COEF-1:0]        coef_in,
    input  logic [8*ngroups(N_COEF)-1:0] bytes_in,
    output logic [2*N_COEF-1:0]        coef_out,
    output logic [8*ngroups(N_COEF)-1:0] bytes_out,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int NG = ngroups(N_COEF);
    localparam int GW = (NG > 1) ? $clog2(NG) : 1;
    localparam int SW = 10 * NG;
    localparam logic [GW-1:0] G_LAST = GW'(NG - 1);

    state_e              state_q, state_d;
    logic [GW-1:0]       g_q, g_d;
    logic                mode_q, mode_d;
    logic [SW-1:0]       src_q, src_d;
    logic                err_q, err_d;
    logic [2*N_COEF-1:0] coef_q, coef_d;
    logic [8*NG-1:0]     bytes_q, bytes_d;

    logic [7:0] pk_byte_s;
    logic [9:0] up_trits_s;
    logic       pk_inv_s;
    logic       up_inv_s;

    // The shift register always presents the current group in its low bits.
    s3_group_conv u_conv (
        .trits_i      (src_q[9:0]),
        .byte_i       (src_q[7:0]),
        .byte_o       (pk_byte_s),
        .trits_o      (up_trits_s),
        .pack_inv_o   (pk_inv_s),
        .unpack_inv_o (up_inv_s)
    );

    // Next-state logic: FSM, group counter, source shift and destination write-back.
    always_comb begin
        int idx;
        idx     = 0;
        state_d = state_q;
        g_d     = g_q;
        mode_d  = mode_q;
        src_d   = src_q;
        err_d   = err_q;
        coef_d  = coef_q;
        bytes_d = bytes_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    g_d     = '0;
                    mode_d  = mode;
                    err_d   = 1'b0;
                    src_d   = '0;
                    if (mode == MODE_PACK) begin
                        src_d[2*N_COEF-1:0] = coef_in;
                        bytes_d             = '0;
                    end else begin
                        src_d[8*NG-1:0] = bytes_in;
                        coef_d          = '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (mode_q == MODE_PACK) begin
                    bytes_d[8*int'(g_q) +: 8] = pk_byte_s;
                    src_d = src_q >> 4'd10;
                    err_d = err_q | pk_inv_s;
                end else begin
                    src_d = src_q >> 4'd8;
                    err_d = err_q | up_inv_s;
                    // Digits beyond the last coefficient are dropped but must be zero.
                    for (int j = 0; j < 5; j++) begin
                        idx = 5 * int'(g_q) + j;
                        if (idx < N_COEF) begin
                            coef_d[2*idx +: 2] = up_trits_s[2*j +: 2];
                        end else if (up_trits_s[2*j +: 2] != TRIT_ZERO) begin
                            err_d = 1'b1;
                        end else begin
                            err_d = err_d;
                        end
                    end
                end
                if (g_q == G_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    g_d = g_q + GW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset to the idle, all-zero condition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            mode_q  <= MODE_PACK;
            src_q   <= '0;
            err_q   <= 1'b0;
            coef_q  <= '0;
            bytes_q <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            err_q   <= err_d;
            coef_q  <= coef_d;
            bytes_q <= bytes_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign coef_out  = coef_q;
    assign bytes_out = bytes_q;

endmodule

// File: tb/tb_s3_pack_codec.sv
// Directed self-checking bench for s3_pack_codec at N_COEF=700 and N_COEF=7.
module tb_s3_pack_codec;

    localparam int NA  = 700;
    localparam int NGA = 140;
    localparam int NB  = 7;
    localparam int NGB = 2;

    logic clk;
    logic rst;

    logic              start_a, mode_a, busy_a, done_a, err_a;
    logic [2*NA-1:0]   coef_in_a, coef_out_a;
    logic [8*NGA-1:0]  bytes_in_a, bytes_out_a;

    logic              start_b, mode_b, busy_b, done_b, err_b;
    logic [2*NB-1:0]   coef_in_b, coef_out_b;
    logic [8*NGB-1:0]  bytes_in_b, bytes_out_b;

    int n_checks;
    int n_fail;
    int dcyc;
    int bcnt;

    s3_pack_codec #(.N_COEF(NA)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode_a),
        .coef_in(coef_in_a), .bytes_in(bytes_in_a),
        .coef_out(coef_out_a), .bytes_out(bytes_out_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    s3_pack_codec #(.N_COEF(NB)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode_b),
        .coef_in(coef_in_b), .bytes_in(bytes_in_b),
        .coef_out(coef_out_b), .bytes_out(bytes_out_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int bytes_ne_a(input logic [7:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NGA; i++) begin
            if (bytes_out_a[8*i +: 8] !== v) n++;
        end
        return n;
    endfunction

    // Start a conversion on DUT A and watch it until done (bounded).
    task automatic run_a(input logic m, input int repulse, output int dc, output int bc);
        int cyc;
        @(negedge clk);
        mode_a  = m;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cyc = 1; dc = 0; bc = 0;
        while (dc == 0 && cyc < 400) begin
            if (busy_a) bc++;
            if (done_a) begin
                dc = cyc;
            end else begin
                if (cyc == repulse) begin start_a = 1'b1; mode_a = ~m; end
                else begin start_a = 1'b0; mode_a = m; end
                @(negedge clk);
                cyc++;
            end
        end
        start_a = 1'b0;
        mode_a  = m;
    endtask

    task automatic run_b(input logic m, output int dc, output int bc);
        int cyc;
        @(negedge clk);
        mode_b  = m;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        cyc = 1; dc = 0; bc = 0;
        while (dc == 0 && cyc < 20) begin
            if (busy_b) bc++;
            if (done_b) begin
                dc = cyc;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1;
        start_a = 1'b0; mode_a = 1'b0; coef_in_a = '0; bytes_in_a = '0;
        start_b = 1'b0; mode_b = 1'b0; coef_in_b = '0; bytes_in_b = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy_a, 1'b0);
        check_eq("rst_done", done_a, 1'b0);
        check_eq("rst_err", err_a, 1'b0);
        check_eq("rst_bytes_zero", bytes_out_a == '0, 1'b1);
        check_eq("rst_coef_zero", coef_out_a == '0, 1'b1);
        check_eq("rst_b_outs", {busy_b, done_b, err_b, coef_out_b, bytes_out_b}, 64'd0);
        rst = 1'b0;

        // Pack all zeros: handshake timing.
        run_a(1'b0, 0, dcyc, bcnt);
        check_eq("zero_done_cycle", dcyc, 141);
        check_eq("zero_busy_cycles", bcnt, 140);
        check_eq("zero_err", err_a, 1'b0);
        check_eq("zero_bytes_ne", bytes_ne_a(8'h00), 0);
        @(negedge clk);
        check_eq("zero_done_pulse", done_a, 1'b0);

        // Pack all twos: every byte 242.
        coef_in_a = {NA{2'b10}};
        run_a(1'b0, 0, dcyc, bcnt);
        check_eq("two_bytes_ne", bytes_ne_a(8'hF2), 0);
        check_eq("two_last_byte", bytes_out_a[8*139 +: 8], 8'hF2);
        check_eq("two_err", err_a, 1'b0);

        // Pack 1,0,2,0,1 with a start re-pulse (inverted mode) mid-run.
        coef_in_a = '0;
        coef_in_a[9:0] = 10'b01_00_10_00_01;
        run_a(1'b0, 10, dcyc, bcnt);
        check_eq("pat_done_cycle", dcyc, 141);
        check_eq("pat_byte0", bytes_out_a[7:0], 8'h64);
        check_eq("pat_byte1", bytes_out_a[15:8], 8'h00);
        check_eq("pat_err", err_a, 1'b0);

        // Pack with coefficient 3 invalid.
        coef_in_a[9:0] = 10'b00_11_00_00_01;
        run_a(1'b0, 0, dcyc, bcnt);
        check_eq("inv_byte0", bytes_out_a[7:0], 8'h01);
        check_eq("inv_err", err_a, 1'b1);

        // Unpack 0xFF: folded to 12 -> 0,1,1,0,0; bytes_out untouched.
        bytes_in_a = '0;
        bytes_in_a[7:0] = 8'hFF;
        run_a(1'b1, 0, dcyc, bcnt);
        check_eq("ff_done_cycle", dcyc, 141);
        check_eq("ff_coef0_4", coef_out_a[9:0], 10'b00_00_01_01_00);
        check_eq("ff_err", err_a, 1'b1);
        check_eq("ff_bytes_held", bytes_out_a[7:0], 8'h01);

        // Unpack 0x64, 0xF2 and last byte 0xF2.
        bytes_in_a[7:0]   = 8'h64;
        bytes_in_a[15:8]  = 8'hF2;
        bytes_in_a[8*139 +: 8] = 8'hF2;
        run_a(1'b1, 0, dcyc, bcnt);
        check_eq("u64_coef0_4", coef_out_a[9:0], 10'b01_00_10_00_01);
        check_eq("uf2_coef5_9", coef_out_a[19:10], 10'b10_10_10_10_10);
        check_eq("uf2_coef695_699", coef_out_a[2*NA-1 -: 10], 10'b10_10_10_10_10);
        check_eq("u64_coef10_19", coef_out_a[39:20], 20'd0);
        check_eq("u64_err", err_a, 1'b0);

        // Small instance: pack coefficients 5,6 = 2,1.
        coef_in_b = 14'b01_10_00_00_00_00_00;
        run_b(1'b0, dcyc, bcnt);
        check_eq("b_done_cycle", dcyc, 3);
        check_eq("b_busy_cycles", bcnt, 2);
        check_eq("b_pack_bytes", bytes_out_b, 16'h0500);
        check_eq("b_pack_err", err_b, 1'b0);

        // Unpack 0x09 into coefficient 5/6: nonzero discarded digit.
        bytes_in_b = 16'h0900;
        run_b(1'b1, dcyc, bcnt);
        check_eq("b_u09_coef", coef_out_b, 14'd0);
        check_eq("b_u09_err", err_b, 1'b1);
        // start raised during done is ignored.
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check_eq("b_start_in_done", busy_b, 1'b0);

        bytes_in_b = 16'h0500;
        run_b(1'b1, dcyc, bcnt);
        check_eq("b_u05_coef", coef_out_b, 14'b01_10_00_00_00_00_00);
        check_eq("b_u05_err", err_b, 1'b0);

        // Reset at cycle 50 of a pack run, then a clean run.
        coef_in_a = {NA{2'b10}};
        @(negedge clk);
        mode_a = 1'b0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (49) @(negedge clk);
        check_eq("mid_byte0_pre", bytes_out_a[7:0], 8'hF2);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", busy_a, 1'b0);
        check_eq("mid_rst_bytes", bytes_out_a == '0, 1'b1);
        check_eq("mid_rst_coef", coef_out_a == '0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        coef_in_a = '0;
        coef_in_a[9:0] = 10'b01_00_10_00_01;
        run_a(1'b0, 0, dcyc, bcnt);
        check_eq("post_rst_done_cycle", dcyc, 141);
        check_eq("post_rst_byte0", bytes_out_a[7:0], 8'h64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
